// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - DES/3DES round-subkey generator with a single rotating C/D pair
// Optional key parity checking is enabled by defining KS_PARITY_CHECK_EN.
module des_key_schedule #(
    parameter int KEYS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [64*KEYS-1:0]  key_in,
    input  logic [KEYS-1:0]     mode,
    output logic                busy,
    output logic                subkey_valid,
    input  logic                subkey_ready,
    output logic [47:0]         subkey,
    output logic [3:0]          round_idx,
    output logic [1:0]          key_idx,
    output logic                last,
    output logic                done,
    output logic                parity_err
);

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    // Bit n-1 set where the shift table entry S[n] is 1 (n = 1, 2, 9, 16).
    localparam logic [15:0] SHIFT_ONE = 16'h8103;
    localparam logic [1:0]  LAST_K    = 2'(KEYS - 1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t       state, state_next;
    logic [191:0] keys_q, key_pad;
    logic [2:0]   mode_q;
    logic [27:0]  c_q, d_q;
    logic [3:0]   rnd_q;
    logic [1:0]   kidx_q, nk;
    logic         done_q;
    logic         accept, fire, end_key, end_job, par_fail;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_T[i]];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_T[i]];
        return r;
    endfunction

    // Encrypt order starts already rotated by S[1]; decrypt order starts at C0/D0 (== C16/D16).
    function automatic logic [55:0] load_cd(input logic [63:0] k, input logic dec);
        logic [55:0] p;
        p = pc1(k);
        return dec ? p : {p[54:28], p[55], p[26:0], p[27]};
    endfunction

    function automatic logic [55:0] step_cd(input logic [55:0] cd, input logic dec, input logic [3:0] nr);
        logic [27:0] c, d;
        logic [3:0]  sidx;
        logic        one;
        c    = cd[55:28];
        d    = cd[27:0];
        sidx = dec ? 4'(5'd16 - {1'b0, nr}) : nr;
        one  = SHIFT_ONE[sidx];
        if (dec) begin
            c = one ? {c[0], c[27:1]} : {c[1:0], c[27:2]};
            d = one ? {d[0], d[27:1]} : {d[1:0], d[27:2]};
        end else begin
            c = one ? {c[26:0], c[27]} : {c[25:0], c[27:26]};
            d = one ? {d[26:0], d[27]} : {d[25:0], d[27:26]};
        end
        return {c, d};
    endfunction

    always_comb begin
        key_pad = '0;
        key_pad[191 -: 64*KEYS] = key_in;
    end

`ifdef KS_PARITY_CHECK_EN
    logic perr_q;
    always_comb begin
        par_fail = 1'b0;
        for (int i = 0; i < 8*KEYS; i++)
            if (!(^key_pad[191-8*i -: 8])) par_fail = 1'b1;
    end
    assign parity_err = perr_q;
`else
    assign par_fail   = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign fire    = subkey_valid & subkey_ready;
    assign end_key = fire && (rnd_q == 4'd15);
    assign end_job = end_key && (kidx_q == LAST_K);
    assign nk      = (kidx_q == LAST_K) ? kidx_q : kidx_q + 2'd1;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: if (start) begin
                accept = 1'b1;
                if (!par_fail) state_next = EMIT;
            end
            EMIT: if (end_job) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            keys_q <= '0;
            mode_q <= '0;
            c_q    <= '0;
            d_q    <= '0;
            rnd_q  <= '0;
            kidx_q <= '0;
            done_q <= 1'b0;
`ifdef KS_PARITY_CHECK_EN
            perr_q <= 1'b0;
`endif
        end else begin
            state  <= state_next;
            done_q <= 1'b0;
            if (accept) begin
                keys_q          <= key_pad;
                mode_q          <= '0;
                mode_q[KEYS-1:0] <= mode;
                rnd_q           <= '0;
                kidx_q          <= '0;
                {c_q, d_q}      <= load_cd(key_pad[191 -: 64], mode[0]);
                done_q          <= par_fail;
`ifdef KS_PARITY_CHECK_EN
                perr_q          <= par_fail;
`endif
            end else if (fire) begin
                if (end_job) begin
                    done_q <= 1'b1;
                    rnd_q  <= '0;
                    kidx_q <= '0;
                end else if (end_key) begin
                    rnd_q      <= '0;
                    kidx_q     <= nk;
                    {c_q, d_q} <= load_cd(keys_q[191 - 64*int'(nk) -: 64], mode_q[nk]);
                end else begin
                    rnd_q      <= rnd_q + 4'd1;
                    {c_q, d_q} <= step_cd({c_q, d_q}, mode_q[kidx_q], rnd_q + 4'd1);
                end
            end
        end
    end

    assign busy         = (state == EMIT);
    assign subkey_valid = busy;
    assign subkey       = busy ? pc2({c_q, d_q}) : 48'd0;
    assign round_idx    = rnd_q;
    assign key_idx      = kidx_q;
    assign last         = busy && (rnd_q == 4'd15) && (kidx_q == LAST_K);
    assign done         = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// tb/tb_des_key_schedule.sv - randomized check of des_key_schedule against a cumulative-rotation model
module tb_des_key_schedule;
    localparam int KEYS = 3;

    logic         clk = 1'b0;
    logic         rst, start, subkey_ready;
    logic [191:0] key_in;
    logic [2:0]   mode;
    logic         busy, subkey_valid, last, done, parity_err;
    logic [47:0]  subkey;
    logic [3:0]   round_idx;
    logic [1:0]   key_idx;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    des_key_schedule #(.KEYS(KEYS)) u_dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in), .mode(mode),
        .busy(busy), .subkey_valid(subkey_valid), .subkey_ready(subkey_ready),
        .subkey(subkey), .round_idx(round_idx), .key_idx(key_idx),
        .last(last), .done(done), .parity_err(parity_err));

    localparam int S_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int PC1_M [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_M [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    typedef struct packed {
        logic [47:0] sk;
        logic [3:0]  r;
        logic [1:0]  k;
        logic        l;
    } exp_t;

    exp_t q[$];
    logic exp_done = 1'b0;
    logic exp_perr = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Subkey K_n is PC2 of PC1(key) rotated left by S[1]+..+S[n]; decrypt order lists K16..K1.
    function automatic logic [47:0] model_subkey(input logic [63:0] key, input logic dec, input int ri);
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] r;
        int n, tot;
        for (int i = 0; i < 28; i++) begin
            c[27-i] = key[64-PC1_M[i]];
            d[27-i] = key[64-PC1_M[28+i]];
        end
        n   = dec ? 16 - ri : ri + 1;
        tot = 0;
        for (int j = 0; j < n; j++) tot += S_T[j];
        for (int j = 0; j < tot; j++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_M[i]];
        return r;
    endfunction

    function automatic logic parity_bad(input logic [191:0] k);
        logic bad;
        bad = 1'b0;
        for (int b = 0; b < 24; b++)
            if ($countones(k[8*b +: 8]) % 2 == 0) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [63:0] rand_key();
        logic [63:0] k;
        k = {$urandom, $urandom};
        for (int b = 0; b < 8; b++) k[8*b] = ~^k[8*b+1 +: 7];
        return k;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            exp_done = 1'b0;
            exp_perr = 1'b0;
        end else begin
            check("busy", busy, q.size() != 0);
            check("subkey_valid", subkey_valid, q.size() != 0);
            check("done", done, exp_done);
            check("parity_err", parity_err, exp_perr);
            if (q.size() != 0) begin
                check("subkey", subkey, q[0].sk);
                check("round_idx", round_idx, q[0].r);
                check("key_idx", key_idx, q[0].k);
                check("last", last, q[0].l);
            end else begin
                check("last_idle", last, 1'b0);
            end
            exp_done = 1'b0;
            if (q.size() != 0) begin
                if (subkey_ready) begin
                    if (q[0].l) exp_done = 1'b1;
                    void'(q.pop_front());
                end
            end else if (start) begin
`ifdef KS_PARITY_CHECK_EN
                if (parity_bad(key_in)) begin
                    exp_done = 1'b1;
                    exp_perr = 1'b1;
                end else
`endif
                begin
                    exp_perr = 1'b0;
                    for (int k = 0; k < KEYS; k++)
                        for (int ri = 0; ri < 16; ri++) begin
                            exp_t e;
                            e.sk = model_subkey(key_in[191-64*k -: 64], mode[k], ri);
                            e.r  = 4'(ri);
                            e.k  = 2'(k);
                            e.l  = (k == KEYS-1) && (ri == 15);
                            q.push_back(e);
                        end
                end
            end
        end
    end

    task automatic start_job(input logic [191:0] k, input logic [2:0] m);
        @(posedge clk); #1;
        key_in = k;
        mode   = m;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd_ready);
        int n;
        n = 0;
        while ((q.size() != 0 || exp_done || busy) && n < 600) begin
            @(posedge clk); #1;
            subkey_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
            key_in       = {rand_key(), rand_key(), rand_key()};
            mode         = 3'($urandom);
            start        = (q.size() > 4) && ($urandom % 4 == 0);
            n++;
        end
        start = 1'b0;
        check("job_timeout", n >= 600, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_valid"}, subkey_valid, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_last"}, last, 1'b0);
        check({tag, "_perr"}, parity_err, 1'b0);
        check({tag, "_subkey"}, subkey, 48'd0);
        check({tag, "_round"}, round_idx, 4'd0);
        check({tag, "_key"}, key_idx, 2'd0);
    endtask

    localparam logic [63:0] REF_KEY = 64'h133457799BBCDFF1;

    initial begin
        int n;
        logic [191:0] kk;
        rst = 1'b1; start = 1'b0; subkey_ready = 1'b0; key_in = '0; mode = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        check("model_k1", model_subkey(REF_KEY, 1'b0, 0), 48'h1B02EFFC7072);
        check("model_k2", model_subkey(REF_KEY, 1'b0, 1), 48'h79AED9DBC9E5);
        check("model_k16", model_subkey(REF_KEY, 1'b0, 15), 48'hCB3D8B0E17F5);
        check("model_dec_first", model_subkey(REF_KEY, 1'b1, 0), 48'hCB3D8B0E17F5);

        // Encrypt run on the reference key: latency, K16 position, last and done timing.
        subkey_ready = 1'b1;
        start_job({REF_KEY, REF_KEY, REF_KEY}, 3'b000);
        check("lat_valid", subkey_valid, 1'b1);
        check("enc_r1", subkey, 48'h1B02EFFC7072);
        n = 1;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (n == 16) check("enc_r16", subkey, 48'hCB3D8B0E17F5);
            if (n == 16) check("enc_r16_not_last", last, 1'b0);
            if (n == 48) check("last_at_48", last, 1'b1);
        end
        check("done_cycle", n, 49);
        check("done_busy", busy, 1'b0);
        wait_idle(1'b0);

        // Decrypt run: order reversed.
        start_job({REF_KEY, REF_KEY, REF_KEY}, 3'b111);
        check("dec_r1", subkey, 48'hCB3D8B0E17F5);
        repeat (15) begin @(posedge clk); #1; end
        check("dec_r16", subkey, 48'h1B02EFFC7072);
        wait_idle(1'b0);

        // EDE keying with distinct random keys, gapless at full throughput.
        start_job({rand_key(), rand_key(), rand_key()}, 3'b010);
        wait_idle(1'b0);

        for (int j = 0; j < 6; j++) begin
            start_job({rand_key(), rand_key(), rand_key()}, 3'($urandom));
            wait_idle(1'b1);
        end

        // Reset during round 7 of key 2, then a fresh job.
        subkey_ready = 1'b1;
        start_job({rand_key(), rand_key(), rand_key()}, 3'($urandom));
        n = 0;
        while (!(subkey_valid && key_idx == 2'd1 && round_idx == 4'd6) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_k2_r7", n < 100, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        check("midrst_no_done", done, 1'b0);
        kk = {rand_key(), rand_key(), rand_key()};
        start_job(kk, 3'b101);
        check("post_rst_valid", subkey_valid, 1'b1);
        check("post_rst_round", round_idx, 4'd0);
        check("post_rst_key", key_idx, 2'd0);
        check("post_rst_subkey", subkey, model_subkey(kk[191 -: 64], 1'b1, 0));
        wait_idle(1'b1);

`ifdef KS_PARITY_CHECK_EN
        start_job({64'h133457799BBCDFF0, REF_KEY, REF_KEY}, 3'b000);
        check("perr_done", done, 1'b1);
        check("perr_flag", parity_err, 1'b1);
        check("perr_no_valid", subkey_valid, 1'b0);
        check("perr_busy", busy, 1'b0);
        @(posedge clk); #1;
        check("perr_hold", parity_err, 1'b1);
        check("perr_done_pulse", done, 1'b0);
        start_job({REF_KEY, REF_KEY, REF_KEY}, 3'b000);
        check("perr_clear", parity_err, 1'b0);
        check("perr_resume", subkey, 48'h1B02EFFC7072);
        wait_idle(1'b0);
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
